alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts ALU commands on a valid/ready channel and drives A, B, sel and Cin onto a registered ALU port set.
- Waits a fixed ALU latency, then captures Y and the four flags and returns them on a valid/ready response channel.
- Holds a carry register so multi-word add/sub chains run without software carry handling.

Parameters:
- WIDTH, 32, operand/result width.
- SEL_W, 4, ALU select width.
- ALU_LAT, 1, cycles from ALU inputs changing to ALU outputs being sampled; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_sel  in  SEL_W  ALU operation select, passed through unmodified.
- cmd_cin  in  1  explicit carry-in.
- cmd_chain  in  1  1: use carry_q as Cin, ignore cmd_cin.
- alu_a  out  WIDTH  registered ALU operand A.
- alu_b  out  WIDTH  registered ALU operand B.
- alu_sel  out  SEL_W  registered ALU select.
- alu_cin  out  1  registered ALU carry-in.
- alu_y  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry-out flag.
- alu_negative  in  1  ALU negative flag.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge.
- rsp_y  out  WIDTH  captured result.
- rsp_flags  out  4  captured {Cout, Negative, Zero, Overflow}.
- carry_q  out  1  stored carry from the last captured result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; alu_a, alu_b, alu_sel, alu_cin, rsp_y, rsp_flags, carry_q all 0; rsp_valid=0; latency counter=0.
- Reset mid-operation abandons the command in flight. No response is ever produced for it.
- States:
  - IDLE: cmd_ready=1. On accept, register operands to alu_* and alu_cin = cmd_chain ? carry_q : cmd_cin. Load counter=ALU_LAT-1 and go to WAIT.
  - WAIT: cmd_ready=0. Counter decrements each cycle. At the edge where counter==0, capture rsp_y=alu_y and rsp_flags={alu_cout, alu_negative, alu_zero, alu_overflow}, set carry_q=alu_cout, set rsp_valid=1, go to RESP.
  - RESP: rsp_valid=1 and rsp_y/rsp_flags held stable until handshake. cmd_ready = rsp_ready (combinational).
    - rsp handshake without cmd_valid: rsp_valid=0, go to IDLE.
    - rsp handshake and cmd handshake in the same cycle: the new command is issued exactly as from IDLE and the state goes to WAIT. A chained new command uses the carry_q just captured.
- Latency: command accepted at edge T gives rsp_valid high after edge T+ALU_LAT. With ALU_LAT=1 and rsp_ready tied high, throughput is one command per 2 cycles.
- alu_* outputs hold their last issued values after capture. They change only on a command accept or reset.
- carry_q is never cleared except by reset. A non-chained command overwrites it at capture.
- No arithmetic is performed in this block. Widths pass through unchanged.
- cmd_* are ignored while cmd_ready=0. rsp_ready is ignored while rsp_valid=0.

Test Plan:
- Bench ALU model: sel=0 is add, sel=1 is sub, ALU_LAT=1.
- Reset, then idle -> all outputs 0, cmd_ready=1, busy=0.
- Add A=32'hFFFF_FFFF, B=1, sel=0, cin=0, rsp_ready=1 -> alu_a/alu_b valid at T+1; rsp_valid at T+1 with rsp_y=0, rsp_flags=4'b1010; carry_q=1.
- Chained add after the above, A=0, B=0, chain=1, cmd_cin=0 -> alu_cin=1, rsp_y=1, rsp_flags=4'b0000, carry_q=0.
- Backpressure: rsp_ready=0 for 5 cycles after response -> rsp_y/rsp_flags stable, cmd_ready=0, a second cmd_valid is not accepted; rsp_ready=1 with cmd_valid=1 -> both handshakes in one cycle, next rsp_valid 1 cycle later.
- ALU_LAT=4: accept at edge T -> rsp_valid rises only after edge T+4; the bench changes alu_y early to verify sampling occurs at counter==0, not earlier.
- Assert rst_n low during WAIT -> rsp_valid never rises, carry_q=0 immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Initiator for a registered ALU port set: issues one command and waits ALU_LAT cycles.
// It then captures the ALU result and flags and returns them on a valid/ready channel.
module alu_cmd_issuer #(
  parameter int WIDTH   = 32,
  parameter int SEL_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_cin,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             carry_q,
  output logic             busy
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic             r_alu_cin;
  logic [WIDTH-1:0] r_rsp_y;
  logic [3:0]       r_rsp_flags;
  logic             r_carry;
  logic             r_rsp_valid;

  logic             w_cmd_ready;
  logic             w_cmd_acc;
  logic             w_capture;
  logic             w_rsp_acc;

  // In RESP the response slot frees up in the same cycle it is consumed,
  // so a new command can be taken back-to-back with the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_capture   = 1'b0;
    w_rsp_acc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_cmd_ready = rsp_ready;
        w_rsp_acc   = rsp_ready;
        if (rsp_ready) w_state_nxt = cmd_valid ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cmd_acc = cmd_valid & w_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cmd_acc) begin
      r_cnt <= LAT_LOAD;
    end else if (r_state == S_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Chained commands take the carry captured from the previous result;
  // in RESP that capture has already landed in r_carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_alu_cin <= 1'b0;
    end else if (w_cmd_acc) begin
      r_alu_a   <= cmd_a;
      r_alu_b   <= cmd_b;
      r_alu_sel <= cmd_sel;
      r_alu_cin <= cmd_chain ? r_carry : cmd_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_y     <= '0;
      r_rsp_flags <= '0;
      r_carry     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else if (w_capture) begin
      r_rsp_y     <= alu_y;
      r_rsp_flags <= {alu_cout, alu_negative, alu_zero, alu_overflow};
      r_carry     <= alu_cout;
      r_rsp_valid <= 1'b1;
    end else if (w_rsp_acc) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign alu_cin   = r_alu_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_flags = r_rsp_flags;
  assign carry_q   = r_carry;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a latency-1 instance with an add/sub ALU model and scoreboard,
// plus a latency-4 instance driven directly to probe sampling time and reset in flight.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU: sel 0 add, sel 1 subtract (A + ~B + Cin), otherwise XOR.
  // Result packs {Y, Cout, Negative, Zero, Overflow}.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] sel, input logic cin);
    logic [32:0] s;
    logic        v;
    if (sel == 4'd0) begin
      s = {1'b0, a} + {1'b0, b} + 33'(cin);
      v = (a[31] == b[31]) && (s[31] != a[31]);
    end else if (sel == 4'd1) begin
      s = {1'b0, a} + {1'b0, ~b} + 33'(cin);
      v = (a[31] != b[31]) && (s[31] != a[31]);
    end else begin
      s = {1'b0, a ^ b};
      v = 1'b0;
    end
    return {s[31:0], s[32], s[31], (s[31:0] == 32'd0), v};
  endfunction

  // ---------------- latency-1 instance ----------------
  logic        c1_cmd_valid = 0, c1_cmd_ready;
  logic [31:0] c1_cmd_a = 0, c1_cmd_b = 0;
  logic [3:0]  c1_cmd_sel = 0;
  logic        c1_cmd_cin = 0, c1_cmd_chain = 0;
  logic [31:0] c1_alu_a, c1_alu_b, c1_alu_y;
  logic [3:0]  c1_alu_sel;
  logic        c1_alu_cin, c1_alu_cout, c1_alu_n, c1_alu_z, c1_alu_v;
  logic        c1_rsp_valid, c1_rsp_ready = 0;
  logic [31:0] c1_rsp_y;
  logic [3:0]  c1_rsp_flags;
  logic        c1_carry_q, c1_busy;
  logic [35:0] c1_res;

  always_comb c1_res = alu_f(c1_alu_a, c1_alu_b, c1_alu_sel, c1_alu_cin);
  assign c1_alu_y = c1_res[35:4];
  assign {c1_alu_cout, c1_alu_n, c1_alu_z, c1_alu_v} = c1_res[3:0];

  alu_cmd_issuer #(.WIDTH(32), .SEL_W(4), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c1_cmd_valid), .cmd_ready(c1_cmd_ready),
    .cmd_a(c1_cmd_a), .cmd_b(c1_cmd_b), .cmd_sel(c1_cmd_sel),
    .cmd_cin(c1_cmd_cin), .cmd_chain(c1_cmd_chain),
    .alu_a(c1_alu_a), .alu_b(c1_alu_b), .alu_sel(c1_alu_sel), .alu_cin(c1_alu_cin),
    .alu_y(c1_alu_y), .alu_cout(c1_alu_cout), .alu_negative(c1_alu_n),
    .alu_zero(c1_alu_z), .alu_overflow(c1_alu_v),
    .rsp_valid(c1_rsp_valid), .rsp_ready(c1_rsp_ready),
    .rsp_y(c1_rsp_y), .rsp_flags(c1_rsp_flags),
    .carry_q(c1_carry_q), .busy(c1_busy)
  );

  // ---------------- latency-4 instance (ALU outputs driven by hand) ----------------
  logic        c4_cmd_valid = 0, c4_cmd_ready;
  logic [31:0] c4_cmd_a = 0, c4_cmd_b = 0;
  logic [3:0]  c4_cmd_sel = 0;
  logic        c4_cmd_cin = 0, c4_cmd_chain = 0;
  logic [31:0] c4_alu_a, c4_alu_b, c4_alu_y = 0;
  logic [3:0]  c4_alu_sel;
  logic        c4_alu_cin, c4_alu_cout = 0, c4_alu_n = 0, c4_alu_z = 0, c4_alu_v = 0;
  logic        c4_rsp_valid, c4_rsp_ready = 0;
  logic [31:0] c4_rsp_y;
  logic [3:0]  c4_rsp_flags;
  logic        c4_carry_q, c4_busy;

  alu_cmd_issuer #(.WIDTH(32), .SEL_W(4), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c4_cmd_valid), .cmd_ready(c4_cmd_ready),
    .cmd_a(c4_cmd_a), .cmd_b(c4_cmd_b), .cmd_sel(c4_cmd_sel),
    .cmd_cin(c4_cmd_cin), .cmd_chain(c4_cmd_chain),
    .alu_a(c4_alu_a), .alu_b(c4_alu_b), .alu_sel(c4_alu_sel), .alu_cin(c4_alu_cin),
    .alu_y(c4_alu_y), .alu_cout(c4_alu_cout), .alu_negative(c4_alu_n),
    .alu_zero(c4_alu_z), .alu_overflow(c4_alu_v),
    .rsp_valid(c4_rsp_valid), .rsp_ready(c4_rsp_ready),
    .rsp_y(c4_rsp_y), .rsp_flags(c4_rsp_flags),
    .carry_q(c4_carry_q), .busy(c4_busy)
  );

  // ---------------- scoreboard for the latency-1 instance ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
    logic [35:0] res;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  logic m_carry = 1'b0;

  task automatic push1();
    exp_t e;
    e.a   = c1_cmd_a;
    e.b   = c1_cmd_b;
    e.sel = c1_cmd_sel;
    e.cin = c1_cmd_chain ? m_carry : c1_cmd_cin;
    e.res = alu_f(e.a, e.b, e.sel, e.cin);
    e.acc = cyc;
    m_carry = e.res[3];
    sbq.push_back(e);
  endtask

  // Drive a command and hold it until the DUT accepts it; returns 1 time unit after the accept edge.
  task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                        input logic cin, input logic chain);
    bit done;
    c1_cmd_a = a; c1_cmd_b = b; c1_cmd_sel = sel; c1_cmd_cin = cin; c1_cmd_chain = chain;
    c1_cmd_valid = 1'b1;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (c1_cmd_ready) begin
        push1();
        done = 1;
      end
      @(posedge clk); #1;
    end
    c1_cmd_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout: command never accepted");
    end
  endtask

  task automatic wait_rsp1(output bit ok);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (c1_rsp_valid) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: rsp_valid never rose");
    end
  endtask

  bit          in_resp = 0;
  logic [31:0] hold_y;
  logic [3:0]  hold_f;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sbq.delete();
      in_resp = 0;
      m_carry = 1'b0;
    end else if (c1_rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected: rsp_valid=1 with nothing outstanding, rsp_y=%0h", c1_rsp_y);
      end else begin
        if (!in_resp) begin
          in_resp = 1;
          hold_y  = c1_rsp_y;
          hold_f  = c1_rsp_flags;
          chk("rsp_latency", 64'(cyc - sbq[0].acc), 64'd2);
        end else begin
          chk("rsp_y_stable", c1_rsp_y, hold_y);
          chk("rsp_flags_stable", c1_rsp_flags, hold_f);
        end
        if (c1_rsp_ready) begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_y", c1_rsp_y, e.res[35:4]);
          chk("rsp_flags", c1_rsp_flags, e.res[3:0]);
          chk("carry_q", c1_carry_q, e.res[3]);
          chk("alu_a", c1_alu_a, e.a);
          chk("alu_b", c1_alu_b, e.b);
          chk("alu_sel", c1_alu_sel, e.sel);
          chk("alu_cin", c1_alu_cin, e.cin);
          in_resp = 0;
        end
      end
    end
  end

  bit rand_rdy = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) c1_rsp_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          ok;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_alu_a", c1_alu_a, 0);
    chk("rst_alu_b", c1_alu_b, 0);
    chk("rst_alu_sel", c1_alu_sel, 0);
    chk("rst_alu_cin", c1_alu_cin, 0);
    chk("rst_rsp_y", c1_rsp_y, 0);
    chk("rst_rsp_flags", c1_rsp_flags, 0);
    chk("rst_carry_q", c1_carry_q, 0);
    chk("rst_rsp_valid", c1_rsp_valid, 0);
    chk("rst_cmd_ready", c1_cmd_ready, 1);
    chk("rst_busy", c1_busy, 0);
    chk("rst4_cmd_ready", c4_cmd_ready, 1);
    chk("rst4_busy", c4_busy, 0);
    @(posedge clk); #1;

    // Add with carry out
    c1_rsp_ready = 1'b1;
    issue1(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0);
    chk("add_alu_a", c1_alu_a, 32'hFFFF_FFFF);
    chk("add_alu_b", c1_alu_b, 32'd1);
    wait_rsp1(ok);
    if (ok) begin
      chk("add_y", c1_rsp_y, 32'd0);
      chk("add_flags", c1_rsp_flags, 4'b1010);
      chk("add_carry", c1_carry_q, 1'b1);
    end
    @(posedge clk); #1;

    // Chained add consumes the stored carry
    issue1(32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    chk("chain_alu_cin", c1_alu_cin, 1'b1);
    wait_rsp1(ok);
    if (ok) begin
      chk("chain_y", c1_rsp_y, 32'd1);
      chk("chain_flags", c1_rsp_flags, 4'b0000);
      chk("chain_carry", c1_carry_q, 1'b0);
    end
    @(posedge clk); #1;

    // Backpressure, then simultaneous response and command handshakes
    c1_rsp_ready = 1'b0;
    issue1(32'h1234_5678, 32'h0000_1111, 4'd1, 1'b1, 1'b0);
    wait_rsp1(ok);
    @(posedge clk); #1;
    c1_cmd_a = 32'hCAFE_0000; c1_cmd_b = 32'h0000_00FF; c1_cmd_sel = 4'd0;
    c1_cmd_cin = 1'b0; c1_cmd_chain = 1'b1; c1_cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_cmd_ready", c1_cmd_ready, 1'b0);
      chk("bp_alu_a_held", c1_alu_a, 32'h1234_5678);
      chk("bp_rsp_valid", c1_rsp_valid, 1'b1);
      @(posedge clk); #1;
    end
    c1_rsp_ready = 1'b1;
    issue1(32'hCAFE_0000, 32'h0000_00FF, 4'd0, 1'b0, 1'b1);
    wait_rsp1(ok);
    @(posedge clk); #1;

    // Randomized traffic with random response backpressure
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = ra;
      issue1(ra, rb, 4'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 0;
    c1_rsp_ready = 1'b1;
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    chk("drain_outstanding", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;

    // Latency-4 instance: ALU output is garbage until just before the sampling edge
    c4_cmd_a = 32'hFFFF_FFFF; c4_cmd_b = 32'd1; c4_cmd_sel = 4'd0;
    c4_cmd_cin = 1'b0; c4_cmd_chain = 1'b0; c4_cmd_valid = 1'b1; c4_rsp_ready = 1'b0;
    @(negedge clk);
    chk("l4_cmd_ready", c4_cmd_ready, 1'b1);
    @(posedge clk); #1;
    c4_cmd_valid = 1'b0;
    chk("l4_alu_a", c4_alu_a, 32'hFFFF_FFFF);
    for (int k = 1; k <= 3; k++) begin
      c4_alu_y = 32'hBAD0_0000 + 32'(k);
      {c4_alu_cout, c4_alu_n, c4_alu_z, c4_alu_v} = 4'b0101;
      @(posedge clk); #1;
      chk("l4_not_yet", c4_rsp_valid, 1'b0);
      chk("l4_busy", c4_busy, 1'b1);
    end
    c4_alu_y = 32'd0;
    {c4_alu_cout, c4_alu_n, c4_alu_z, c4_alu_v} = 4'b1010;
    @(posedge clk); #1;
    chk("l4_rsp_valid", c4_rsp_valid, 1'b1);
    chk("l4_rsp_y", c4_rsp_y, 32'd0);
    chk("l4_rsp_flags", c4_rsp_flags, 4'b1010);
    chk("l4_carry", c4_carry_q, 1'b1);
    c4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("l4_rsp_done", c4_rsp_valid, 1'b0);
    chk("l4_idle_ready", c4_cmd_ready, 1'b1);
    c4_rsp_ready = 1'b0;

    // Reset while the latency-4 instance is waiting on the ALU
    c4_cmd_a = 32'd5; c4_cmd_b = 32'd6; c4_cmd_valid = 1'b1;
    @(posedge clk); #1;
    c4_cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rw_busy", c4_busy, 1'b1);
    chk("rw_carry_before", c4_carry_q, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_carry_cleared", c4_carry_q, 1'b0);
    chk("rw_busy_cleared", c4_busy, 1'b0);
    chk("rw_alu_a_cleared", c4_alu_a, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rw_cmd_ready", c4_cmd_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rw_no_rsp", c4_rsp_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
